// File: rtl/multicycle_pkg.sv
// Shared constants for the multi-cycle RV32I controller: opcodes, states, ALU classes, mux selects.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package multicycle_pkg;

   localparam logic [6:0] OP_R      = 7'h33;
   localparam logic [6:0] OP_I      = 7'h13;
   localparam logic [6:0] OP_LW     = 7'h03;
   localparam logic [6:0] OP_SW     = 7'h23;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_BRANCH = 7'h63;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXEC_R    = 4'd6,
      S_EXEC_I    = 4'd7,
      S_ALU_WB    = 4'd8,
      S_BRANCH    = 4'd9,
      S_JAL       = 4'd10,
      S_JALR      = 4'd11,
      S_LUI       = 4'd12,
      S_TRAP      = 4'd13
   } state_t;

   localparam logic [3:0] ALU_R       = 4'b0000;
   localparam logic [3:0] ALU_I_LOGIC = 4'b0001;
   localparam logic [3:0] ALU_LUI     = 4'b0010;
   localparam logic [3:0] ALU_SW      = 4'b0011;
   localparam logic [3:0] ALU_LW      = 4'b0100;
   localparam logic [3:0] ALU_JAL     = 4'b0101;
   localparam logic [3:0] ALU_JALR    = 4'b0110;
   localparam logic [3:0] ALU_BRANCH  = 4'b0111;
   localparam logic [3:0] ALU_ADD     = 4'b1000;

   localparam logic [1:0] M2R_ALUOUT = 2'b00;
   localparam logic [1:0] M2R_MDR    = 2'b01;
   localparam logic [1:0] M2R_PC     = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;

   localparam logic PCSRC_ALU    = 1'b0;
   localparam logic PCSRC_ALUOUT = 1'b1;

   // States that sit on the memory port until Mem_Ready_i
   function automatic logic is_wait_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle controller and its datapath / memory port.
// Latency: n/a (wiring only).
// Backpressure: Mem_Ready_i is the only stall input; the controller holds its strobes while it is low.
interface multicycle_control_if #(
   parameter int ALU_OP_WIDTH = 4
);
   logic [6:0]              OP_i;
   logic                    Zero_i;
   logic                    Mem_Ready_i;
   logic                    PC_Write_o;
   logic                    IR_Write_o;
   logic                    IorD_o;
   logic                    Mem_Read_o;
   logic                    Mem_Write_o;
   logic                    Reg_Write_o;
   logic [1:0]              Mem_to_Reg_o;
   logic [1:0]              ALU_Src_A_o;
   logic [1:0]              ALU_Src_B_o;
   logic [ALU_OP_WIDTH-1:0] ALU_Op_o;
   logic                    PC_Src_o;
   logic                    Instr_Done_o;
   logic                    Illegal_Op_o;
   logic                    Bus_Error_o;
   logic [3:0]              State_o;

   // Controller side
   modport master (
      input  OP_i, Zero_i, Mem_Ready_i,
      output PC_Write_o, IR_Write_o, IorD_o, Mem_Read_o, Mem_Write_o, Reg_Write_o,
             Mem_to_Reg_o, ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o, PC_Src_o,
             Instr_Done_o, Illegal_Op_o, Bus_Error_o, State_o
   );

   // Datapath / memory side
   modport slave (
      output OP_i, Zero_i, Mem_Ready_i,
      input  PC_Write_o, IR_Write_o, IorD_o, Mem_Read_o, Mem_Write_o, Reg_Write_o,
             Mem_to_Reg_o, ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o, PC_Src_o,
             Instr_Done_o, Illegal_Op_o, Bus_Error_o, State_o
   );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles in a memory wait state and flags a timeout.
// Latency: timeout is combinational in the last allowed wait cycle (count registered).
// Backpressure: none; a ready in the timeout cycle suppresses the timeout.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic waiting,
   input  logic ready,
   output logic timeout
);
   localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX  = CW'(MEM_TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   logic [CW-1:0] cnt;

   // Clear on entry to a wait state, then count stalled cycles, saturating at the limit
   always_ff @(posedge clk) begin
      if (reset || start)
         cnt <= '0;
      else if (waiting && !ready && cnt != CNT_MAX)
         cnt <= cnt + CW'(1);
   end

   // Fires when this stalled cycle would bring the count to the limit
   assign timeout = (MEM_TIMEOUT != 0) && waiting && !ready && (cnt == CNT_LAST);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback, Moore strobes per state.
// Latency: 3 to 5 cycles per instruction with zero wait states, plus memory stall cycles.
// Backpressure: stalls in FETCH/MEM_READ/MEM_WRITE on Mem_Ready_i; traps after MEM_TIMEOUT stalled cycles.
module multicycle_control
   import multicycle_pkg::*;
#(
   parameter int ALU_OP_WIDTH  = 4,
   parameter int MEM_TIMEOUT   = 16,
   parameter int ENABLE_BRANCH = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   multicycle_control_if.master bus
);
   state_t     state, state_nxt, eff_state;
   logic       timeout, in_wait, timer_start, rdy;
   logic       illegal_q, bus_err_q;
   logic [3:0] alu_op;

   assign in_wait     = is_wait_state(state);
   assign timer_start = is_wait_state(state_nxt) && (state_nxt != state);

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .start   (timer_start),
      .waiting (in_wait),
      .ready   (bus.Mem_Ready_i),
      .timeout (timeout)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= state_nxt;
   end

   // Next-state sequencing
   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH:     if (timeout) state_nxt = S_TRAP; else if (bus.Mem_Ready_i) state_nxt = S_DECODE;
         S_DECODE: begin
            case (bus.OP_i)
               OP_R:            state_nxt = S_EXEC_R;
               OP_I:            state_nxt = S_EXEC_I;
               OP_LW, OP_SW:    state_nxt = S_MEM_ADDR;
               OP_LUI:          state_nxt = S_LUI;
               OP_JAL:          state_nxt = S_JAL;
               OP_JALR:         state_nxt = S_JALR;
               OP_BRANCH:       state_nxt = (ENABLE_BRANCH != 0) ? S_BRANCH : S_TRAP;
               default:         state_nxt = S_TRAP;
            endcase
         end
         S_MEM_ADDR:  state_nxt = (bus.OP_i == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  if (timeout) state_nxt = S_TRAP; else if (bus.Mem_Ready_i) state_nxt = S_MEM_WB;
         S_MEM_WRITE: if (timeout) state_nxt = S_TRAP; else if (bus.Mem_Ready_i) state_nxt = S_FETCH;
         S_EXEC_R, S_EXEC_I: state_nxt = S_ALU_WB;
         S_MEM_WB, S_ALU_WB, S_LUI, S_JAL, S_JALR, S_BRANCH: state_nxt = S_FETCH;
         S_TRAP:      state_nxt = S_TRAP;
         default:     state_nxt = S_FETCH;
      endcase
   end

   // Sticky trap cause flags, set on the edge that enters TRAP
   always_ff @(posedge clk) begin
      if (reset) begin
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         if (state == S_DECODE && state_nxt == S_TRAP) illegal_q <= 1'b1;
         if (timeout) bus_err_q <= 1'b1;
      end
   end

   // Moore strobes; during reset the outputs look like a stalled FETCH so nothing is written
   always_comb begin
      eff_state        = reset ? S_FETCH : state;
      rdy              = bus.Mem_Ready_i & ~reset;
      alu_op           = ALU_R;
      bus.PC_Write_o   = 1'b0;
      bus.IR_Write_o   = 1'b0;
      bus.IorD_o       = 1'b0;
      bus.Mem_Read_o   = 1'b0;
      bus.Mem_Write_o  = 1'b0;
      bus.Reg_Write_o  = 1'b0;
      bus.Mem_to_Reg_o = M2R_ALUOUT;
      bus.ALU_Src_A_o  = SRCA_PC;
      bus.ALU_Src_B_o  = SRCB_RS2;
      bus.PC_Src_o     = PCSRC_ALU;
      bus.Instr_Done_o = 1'b0;
      case (eff_state)
         S_FETCH: begin
            bus.Mem_Read_o = 1'b1; bus.ALU_Src_B_o = SRCB_FOUR; alu_op = ALU_ADD;
            bus.IR_Write_o = rdy;  bus.PC_Write_o = rdy;
         end
         S_DECODE: begin
            bus.ALU_Src_A_o = SRCA_OLDPC; bus.ALU_Src_B_o = SRCB_IMM; alu_op = ALU_ADD;
         end
         S_MEM_ADDR: begin
            bus.ALU_Src_A_o = SRCA_RS1; bus.ALU_Src_B_o = SRCB_IMM;
            alu_op = (bus.OP_i == OP_LW) ? ALU_LW : ALU_SW;
         end
         S_MEM_READ:  begin bus.Mem_Read_o = 1'b1; bus.IorD_o = 1'b1; end
         S_MEM_WB: begin
            bus.Reg_Write_o = 1'b1; bus.Mem_to_Reg_o = M2R_MDR; bus.Instr_Done_o = 1'b1;
         end
         S_MEM_WRITE: begin
            bus.Mem_Write_o = 1'b1; bus.IorD_o = 1'b1; bus.Instr_Done_o = rdy;
         end
         S_EXEC_R: begin bus.ALU_Src_A_o = SRCA_RS1; bus.ALU_Src_B_o = SRCB_RS2; alu_op = ALU_R; end
         S_EXEC_I: begin bus.ALU_Src_A_o = SRCA_RS1; bus.ALU_Src_B_o = SRCB_IMM; alu_op = ALU_I_LOGIC; end
         S_ALU_WB: begin bus.Reg_Write_o = 1'b1; bus.Instr_Done_o = 1'b1; end
         S_LUI: begin
            bus.ALU_Src_B_o = SRCB_IMM; alu_op = ALU_LUI;
            bus.Reg_Write_o = 1'b1; bus.Instr_Done_o = 1'b1;
         end
         S_JAL: begin
            bus.Reg_Write_o = 1'b1; bus.Mem_to_Reg_o = M2R_PC; bus.PC_Write_o = 1'b1;
            bus.PC_Src_o = PCSRC_ALUOUT; alu_op = ALU_JAL; bus.Instr_Done_o = 1'b1;
         end
         S_JALR: begin
            bus.Reg_Write_o = 1'b1; bus.Mem_to_Reg_o = M2R_PC;
            bus.ALU_Src_A_o = SRCA_RS1; bus.ALU_Src_B_o = SRCB_IMM; alu_op = ALU_JALR;
            bus.PC_Write_o = 1'b1; bus.Instr_Done_o = 1'b1;
         end
         S_BRANCH: begin
            bus.ALU_Src_A_o = SRCA_RS1; bus.ALU_Src_B_o = SRCB_RS2; alu_op = ALU_BRANCH;
            bus.PC_Src_o = PCSRC_ALUOUT; bus.PC_Write_o = bus.Zero_i; bus.Instr_Done_o = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.ALU_Op_o     = ALU_OP_WIDTH'(alu_op);
   assign bus.State_o      = eff_state;
   assign bus.Illegal_Op_o = illegal_q & ~reset;
   assign bus.Bus_Error_o  = bus_err_q & ~reset;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios then randomized instruction stream.
// Latency: checks every cycle against an instruction-level model of expected state and strobes.
// Backpressure: random memory stall lengths, including the timeout boundary.
module tb_multicycle_control;

   localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MADDR = 2, ST_MREAD = 3, ST_MWB = 4,
                  ST_MWRITE = 5, ST_EXR = 6, ST_EXI = 7, ST_ALUWB = 8, ST_BR = 9,
                  ST_JAL = 10, ST_JALR = 11, ST_LUI = 12, ST_TRAP = 13;
   localparam int TIMEOUT = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   bit   exp_ill = 1'b0;
   bit   exp_bus = 1'b0;

   always #5 clk = ~clk;

   multicycle_control_if #(.ALU_OP_WIDTH(4)) bus ();

   multicycle_control #(.ALU_OP_WIDTH(4), .MEM_TIMEOUT(TIMEOUT), .ENABLE_BRANCH(1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Expected strobe word for one state, straight from the per-state output table
   function automatic logic [17:0] exp_ctrl(input int st, input bit rdy, input bit zero, input logic [6:0] op);
      logic pcw, irw, iord, mr, mw, rw, pcs, done;
      logic [1:0] m2r, sa, sb;
      logic [3:0] aop;
      {pcw, irw, iord, mr, mw, rw, pcs, done} = 8'b0;
      m2r = 2'd0; sa = 2'd0; sb = 2'd0; aop = 4'd0;
      case (st)
         ST_FETCH:  begin mr = 1; sb = 2'd1; aop = 4'd8; irw = rdy; pcw = rdy; end
         ST_DECODE: begin sa = 2'd1; sb = 2'd2; aop = 4'd8; end
         ST_MADDR:  begin sa = 2'd2; sb = 2'd2; aop = (op == 7'h03) ? 4'd4 : 4'd3; end
         ST_MREAD:  begin mr = 1; iord = 1; end
         ST_MWB:    begin rw = 1; m2r = 2'd1; done = 1; end
         ST_MWRITE: begin mw = 1; iord = 1; done = rdy; end
         ST_EXR:    begin sa = 2'd2; sb = 2'd0; aop = 4'd0; end
         ST_EXI:    begin sa = 2'd2; sb = 2'd2; aop = 4'd1; end
         ST_ALUWB:  begin rw = 1; done = 1; end
         ST_BR:     begin sa = 2'd2; aop = 4'd7; pcs = 1; pcw = zero; done = 1; end
         ST_JAL:    begin rw = 1; m2r = 2'd2; pcw = 1; pcs = 1; aop = 4'd5; done = 1; end
         ST_JALR:   begin rw = 1; m2r = 2'd2; sa = 2'd2; sb = 2'd2; aop = 4'd6; pcw = 1; done = 1; end
         ST_LUI:    begin sb = 2'd2; aop = 4'd2; rw = 1; done = 1; end
         default: ;
      endcase
      return {pcw, irw, iord, mr, mw, rw, m2r, sa, sb, aop, pcs, done};
   endfunction

   // One clock cycle: drive inputs at edge+1, check at edge+2, advance to next edge+1
   task automatic cyc(input int st, input bit rdy_drv, input bit zero, input logic [6:0] op, input string tag);
      logic [17:0] obs, exp_w;
      bus.OP_i = op; bus.Zero_i = zero; bus.Mem_Ready_i = rdy_drv;
      #1;
      obs = {bus.PC_Write_o, bus.IR_Write_o, bus.IorD_o, bus.Mem_Read_o, bus.Mem_Write_o,
             bus.Reg_Write_o, bus.Mem_to_Reg_o, bus.ALU_Src_A_o, bus.ALU_Src_B_o,
             bus.ALU_Op_o, bus.PC_Src_o, bus.Instr_Done_o};
      exp_w = exp_ctrl(st, rdy_drv & ~reset, zero, op);
      checks++;
      assert (bus.State_o === 4'(st)) else begin
         errors++; $error("FAIL %s state got %0d want %0d", tag, bus.State_o, st);
      end
      checks++;
      assert (obs === exp_w) else begin
         errors++; $error("FAIL %s ctrl got %h want %h (state %0d)", tag, obs, exp_w, st);
      end
      checks++;
      assert ({bus.Illegal_Op_o, bus.Bus_Error_o} === ({exp_ill, exp_bus} & {2{~reset}})) else begin
         errors++; $error("FAIL %s flags got %b%b want %b%b", tag, bus.Illegal_Op_o, bus.Bus_Error_o,
                          exp_ill & ~reset, exp_bus & ~reset);
      end
      @(posedge clk); #1;
   endtask

   task automatic trap_hold(input int n, input logic [6:0] op);
      for (int i = 0; i < n; i++) cyc(ST_TRAP, 1'($urandom), 1'($urandom), op, "trap");
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(ST_FETCH, 1'($urandom), 1'($urandom), 7'($urandom), "reset");
      reset = 1'b0;
      exp_ill = 1'b0;
      exp_bus = 1'b0;
   endtask

   // A wait state stalled for w cycles; beyond the timeout budget it enters TRAP
   task automatic wait_phase(input int st, input int w, input bit zero, input logic [6:0] op, output bit to);
      int n;
      n = 0;
      to = 1'b0;
      while (n < w && n < TIMEOUT) begin
         cyc(st, 1'b0, zero, op, "stall");
         n++;
      end
      if (n == TIMEOUT) begin
         exp_bus = 1'b1;
         trap_hold(6, op);
         to = 1'b1;
      end else begin
         cyc(st, 1'b1, zero, op, "ready");
      end
   endtask

   // Whole instruction from FETCH to retirement (or TRAP)
   task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input bit zero, output bit trapped);
      bit to;
      trapped = 1'b0;
      wait_phase(ST_FETCH, fw, zero, op, to);
      if (to) begin trapped = 1'b1; return; end
      cyc(ST_DECODE, 1'($urandom), zero, op, "decode");
      case (op)
         7'h33: begin cyc(ST_EXR, 1'($urandom), zero, op, "exec_r"); cyc(ST_ALUWB, 1'($urandom), zero, op, "wb_r"); end
         7'h13: begin cyc(ST_EXI, 1'($urandom), zero, op, "exec_i"); cyc(ST_ALUWB, 1'($urandom), zero, op, "wb_i"); end
         7'h03: begin
            cyc(ST_MADDR, 1'($urandom), zero, op, "addr_lw");
            wait_phase(ST_MREAD, mw, zero, op, to);
            if (to) begin trapped = 1'b1; return; end
            cyc(ST_MWB, 1'($urandom), zero, op, "mem_wb");
         end
         7'h23: begin
            cyc(ST_MADDR, 1'($urandom), zero, op, "addr_sw");
            wait_phase(ST_MWRITE, mw, zero, op, to);
            if (to) begin trapped = 1'b1; return; end
         end
         7'h37: cyc(ST_LUI, 1'($urandom), zero, op, "lui");
         7'h6F: cyc(ST_JAL, 1'($urandom), zero, op, "jal");
         7'h67: cyc(ST_JALR, 1'($urandom), zero, op, "jalr");
         7'h63: cyc(ST_BR, 1'($urandom), zero, op, "branch");
         default: begin
            exp_ill = 1'b1;
            trap_hold(20, op);
            trapped = 1'b1;
         end
      endcase
   endtask

   logic [6:0] op_pool [12] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h6F, 7'h67, 7'h63,
                                7'h7F, 7'h00, 7'h0F, 7'h73};

   initial begin
      bit tr;
      int fw, mw;
      logic [6:0] op;
      bus.OP_i = 7'h00; bus.Zero_i = 1'b0; bus.Mem_Ready_i = 1'b0;
      @(posedge clk); #1;
      do_reset();

      run_instr(7'h33, 0, 0, 1'b0, tr);           // R-type, no stalls
      run_instr(7'h03, 0, 3, 1'b0, tr);           // LW, 3 stall cycles in MEM_READ
      run_instr(7'h63, 0, 0, 1'b1, tr);           // branch taken
      run_instr(7'h63, 0, 0, 1'b0, tr);           // branch not taken
      run_instr(7'h23, 2, 1, 1'b0, tr);           // SW with stalls
      run_instr(7'h7F, 0, 0, 1'b0, tr);           // illegal opcode
      do_reset();
      run_instr(7'h13, TIMEOUT, 0, 1'b0, tr);     // fetch timeout
      do_reset();
      run_instr(7'h13, TIMEOUT - 1, 0, 1'b0, tr); // ready in the timeout cycle wins
      run_instr(7'h03, 0, TIMEOUT, 1'b0, tr);     // MEM_READ timeout
      do_reset();

      // JAL aborted by reset in its DECODE cycle, with ready held high
      cyc(ST_FETCH, 1'b1, 1'b0, 7'h6F, "jal_fetch");
      reset = 1'b1;
      cyc(ST_FETCH, 1'b1, 1'b0, 7'h6F, "jal_abort");
      reset = 1'b0;
      exp_ill = 1'b0; exp_bus = 1'b0;
      run_instr(7'h37, 1, 0, 1'b0, tr);

      for (int i = 0; i < 40; i++) begin
         op = op_pool[$urandom_range(0, 11)];
         fw = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT) : $urandom_range(0, 3);
         mw = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT) : $urandom_range(0, 3);
         run_instr(op, fw, mw, 1'($urandom), tr);
         if (tr) do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
